mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Sequencer for the CPU's memory path. It accepts one read or write request at a time from the control unit. It strobes the MAR latch, waits a fixed RAM latency, then moves data between RAM and MDR. It reports completion with a one-cycle done pulse. It sits between the control unit FSM and the MAR/MDR/RAM trio on the shared 16-bit DATA bus, and never drives DATA itself.

Parameters:
RAM_LAT, 2, RAM access wait cycles between address latch and data transfer; legal range 0..15.
CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > RAM_LAT.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset
rd_req  input  1  read request from control unit; held high until done
wr_req  input  1  write request from control unit; held high until done
mar_in  output  1  MAR latch strobe; requester has the address on DATA this cycle
ram_re  output  1  RAM read enable during WAIT and XFER of a read
ram_we  output  1  RAM write strobe, one cycle, during XFER of a write
mdr_ld_mem  output  1  MDR loads from RAM data, one cycle, XFER of a read
mdr_to_mem  output  1  MDR drives RAM write data during WAIT and XFER of a write
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
acc_cnt  output  16  completed-access count (only with MEM_ACCESS_CNT_EN)

Behaviour:
- Reset (reset==0 at posedge):
  - state <= IDLE, wait counter <= 0, latched op <= READ.
  - All outputs are 0 from the following cycle.
  - Reset overrides any state, including mid-access; no done is produced for an aborted access.
- Outputs are Moore-decoded from the registered state and latched op; no combinational path from rd_req/wr_req to any output.
- States:
  - IDLE: samples requests. rd_req has priority; if both are high, a read is latched and wr_req is ignored until a later IDLE. With either request high: latch op, go to ADDR. With neither: stay.
  - ADDR: mar_in=1 for exactly one cycle. Counter <= RAM_LAT. Next state is WAIT if RAM_LAT>0, else XFER.
  - WAIT: ram_re=1 (read) or mdr_to_mem=1 (write). Counter decrements each cycle; at counter==1 go to XFER. Occupancy is exactly RAM_LAT cycles.
  - XFER: for a read, ram_re=1 and mdr_ld_mem=1. For a write, mdr_to_mem=1 and ram_we=1. Lasts one cycle, then DONE.
  - DONE: done=1 for one cycle, then IDLE unconditionally.
- Latency from the request being sampled in IDLE to done high is RAM_LAT+3 cycles: ADDR, WAIT×RAM_LAT, XFER, DONE.
- The requester must drop its request in the cycle done is high. A request still high in the following IDLE starts a new access, which is how back-to-back accesses are made.
- The op is latched in IDLE. Request changes during ADDR, WAIT, XFER or DONE have no effect.
- Exactly one of ram_we/mdr_ld_mem pulses per access; mar_in pulses exactly once per access.
- busy=1 from ADDR through DONE inclusive.

Optional Feature:
MEM_ACCESS_CNT_EN
- Defined:
  - acc_cnt is a 16-bit register, reset to 0.
  - It increments by 1 on the posedge leaving DONE and wraps 0xFFFF -> 0x0000.
  - Aborted accesses are not counted.
- Undefined: the acc_cnt port is absent and no counter logic exists.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state encoding IDLE=0, ADDR=1, WAIT=2, XFER=3, DONE=4 (3 bits);
  - op encoding OP_RD=0, OP_WR=1;
  - default RAM_LAT constant.
- One sub-module, mem_wait_timer:
  - loadable down-counter of width CNT_W with load, dec and last (count==1) outputs;
  - instantiated once by the FSM.

Test Plan:
- RAM_LAT=2, rd_req rises at cycle 0:
  - mar_in=1 in cycle 1;
  - ram_re=1 in cycles 2-4;
  - mdr_ld_mem=1 in cycle 4;
  - done=1 in cycle 5;
  - busy=1 in cycles 1-5;
  - ram_we never asserted.
- RAM_LAT=2, wr_req at cycle 0:
  - mar_in in cycle 1;
  - mdr_to_mem in cycles 2-4;
  - ram_we=1 in cycle 4 only;
  - done in cycle 5;
  - mdr_ld_mem never asserted.
- RAM_LAT=0, rd_req:
  - mar_in in cycle 1, XFER in cycle 2, done in cycle 3;
  - no WAIT cycle.
- rd_req and wr_req both high at cycle 0, with rd_req dropped at done and wr_req held:
  - read completes at cycle 5;
  - write starts with mar_in in cycle 7;
  - write's done in cycle 11.
- reset low during WAIT (cycle 3 of a read):
  - every output is 0 from cycle 4;
  - no done;
  - with MEM_ACCESS_CNT_EN, acc_cnt=0.
- MEM_ACCESS_CNT_EN with acc_cnt preloaded to 0xFFFF by forcing, after one completed access:
  - acc_cnt=0x0000.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/strobe bundle between the control unit and the MAR/MDR/RAM sequencer.
// Latency: n/a (wires only); acc_cnt exists only when MEM_ACCESS_CNT_EN is defined.
// Backpressure: requests are level-held until done; there is no ready signal.
interface mem_access_ctrl_if;
    logic        rd_req;
    logic        wr_req;
    logic        mar_in;
    logic        ram_re;
    logic        ram_we;
    logic        mdr_ld_mem;
    logic        mdr_to_mem;
    logic        busy;
    logic        done;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] acc_cnt;
`endif

    // Requester side (control unit).
    modport master (
`ifdef MEM_ACCESS_CNT_EN
        input  acc_cnt,
`endif
        output rd_req, wr_req,
        input  mar_in, ram_re, ram_we, mdr_ld_mem, mdr_to_mem, busy, done
    );

    // Sequencer side.
    modport slave (
`ifdef MEM_ACCESS_CNT_EN
        output acc_cnt,
`endif
        input  rd_req, wr_req,
        output mar_in, ram_re, ram_we, mdr_ld_mem, mdr_to_mem, busy, done
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times the RAM access wait; last flags count==1.
// Latency: load/dec take effect on the next posedge; last is registered-state decode.
// Backpressure: none; the owner decides when to load and decrement.
module mem_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Counter register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer for MAR strobe, fixed RAM wait, then RAM<->MDR transfer; acc_cnt with MEM_ACCESS_CNT_EN.
// Latency: RAM_LAT+3 cycles from request sampled in IDLE to the one-cycle done pulse.
// Backpressure: one access at a time; requests are ignored outside IDLE and must drop with done.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_LAT = RAM_LAT_DEFAULT,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);

    state_t state, state_nxt;
    op_t    op, op_nxt;
    logic   tmr_load;
    logic   tmr_dec;
    logic   tmr_last;

    mem_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (CNT_W'(RAM_LAT)),
        .dec      (tmr_dec),
        .last     (tmr_last)
    );

    // State and latched-op registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            op    <= OP_RD;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
        end
    end

    // Next-state and Moore output decode; outputs depend only on state and op.
    always_comb begin
        state_nxt      = state;
        op_nxt         = op;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        bus.mar_in     = 1'b0;
        bus.ram_re     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.mdr_ld_mem = 1'b0;
        bus.mdr_to_mem = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Read wins when both are raised; the write waits for a later IDLE.
                if (bus.rd_req) begin
                    op_nxt    = OP_RD;
                    state_nxt = ADDR;
                end else if (bus.wr_req) begin
                    op_nxt    = OP_WR;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus.mar_in = 1'b1;
                tmr_load   = 1'b1;
                state_nxt  = (RAM_LAT > 0) ? WAIT : XFER;
            end
            WAIT: begin
                bus.ram_re     = (op == OP_RD);
                bus.mdr_to_mem = (op == OP_WR);
                tmr_dec        = 1'b1;
                if (tmr_last) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                bus.ram_re     = (op == OP_RD);
                bus.mdr_ld_mem = (op == OP_RD);
                bus.mdr_to_mem = (op == OP_WR);
                bus.ram_we     = (op == OP_WR);
                state_nxt      = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] acc_cnt_q;

    // Completed-access counter; only the DONE exit counts, so aborts are never counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_cnt_q <= 16'h0000;
        end else if (state == DONE) begin
            acc_cnt_q <= acc_cnt_q + 16'h0001;
        end
    end

    assign bus.acc_cnt = acc_cnt_q;
`endif

endmodule
